// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and single-access sequencer
// for the 16-bit data memory. Port 0 is the CPU load/store stage, port 1 the
// loader/debug port. Each grant runs IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_TOP = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              Rm,
  output logic              Wm,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] RegVal,
  input  logic [DATA_W-1:0] Data_out
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(MEM_TOP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Latched transaction attributes; address/RegVal double as the latched
  // address and write data so they hold their value outside ACCESS.
  logic lat_we, lat_port, lat_oor;
  logic lat_we_nx, lat_port_nx, lat_oor_nx;
  logic last_gnt, last_gnt_nx;

  logic [ADDR_W-1:0] address_nx;
  logic [DATA_W-1:0] regval_nx;
  logic              rm_nx, wm_nx;
  logic              ack0_nx, ack1_nx, err0_nx, err1_nx;
  logic [DATA_W-1:0] rdata0_nx, rdata1_nx;

  logic              win_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_oor;

  // Winner select: a tie goes to the port that was not granted last.
  always_comb begin
    win_port  = (req0 && req1) ? ~last_gnt : req1;
    win_we    = win_port ? we1    : we0;
    win_addr  = win_port ? addr1  : addr0;
    win_wdata = win_port ? wdata1 : wdata0;
    win_oor   = (win_addr > TOP);
  end

  // Next-state and next-register values; strobes/acks default to 0 so they
  // are high only in their own registered cycle.
  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    lat_we_nx   = lat_we;
    lat_port_nx = lat_port;
    lat_oor_nx  = lat_oor;
    address_nx  = address;
    regval_nx   = RegVal;
    rm_nx       = 1'b0;
    wm_nx       = 1'b0;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    err0_nx     = 1'b0;
    err1_nx     = 1'b0;
    rdata0_nx   = rdata0;
    rdata1_nx   = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx    = ACCESS;
          last_gnt_nx = win_port;
          lat_we_nx   = win_we;
          lat_port_nx = win_port;
          lat_oor_nx  = win_oor;
          address_nx  = win_addr;
          regval_nx   = win_wdata;
          rm_nx       = !win_oor && !win_we;
          wm_nx       = !win_oor && win_we;
        end
      end
      ACCESS: begin
        state_nx = RESP;
        if (!lat_we) begin
          if (lat_port) rdata1_nx = lat_oor ? '0 : Data_out;
          else          rdata0_nx = lat_oor ? '0 : Data_out;
        end
        if (lat_port) begin
          ack1_nx = 1'b1;
          err1_nx = lat_oor;
        end else begin
          ack0_nx = 1'b1;
          err0_nx = lat_oor;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath and registered output register bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= 1'b1;
      lat_we   <= 1'b0;
      lat_port <= 1'b0;
      lat_oor  <= 1'b0;
      address  <= '0;
      RegVal   <= '0;
      Rm       <= 1'b0;
      Wm       <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      last_gnt <= last_gnt_nx;
      lat_we   <= lat_we_nx;
      lat_port <= lat_port_nx;
      lat_oor  <= lat_oor_nx;
      address  <= address_nx;
      RegVal   <= regval_nx;
      Rm       <= rm_nx;
      Wm       <= wm_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      err0     <= err0_nx;
      err1     <= err1_nx;
      rdata0   <= rdata0_nx;
      rdata1   <= rdata1_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed vectors plus hand-written multi-cycle
// sequences for reset, continuous contention, mid-access reset and a dropped
// request. Includes a behavioural 513-entry memory written on the falling edge.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        busy, Rm, Wm;
  logic [15:0] address, RegVal, Data_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:512];

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_TOP(512)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal),
    .Data_out(Data_out)
  );

  always #5 clock = ~clock;

  // Memory: write on the falling edge, read combinationally while Rm is high.
  always @(negedge clock) begin
    if (Wm && address <= 16'd512) mem[address[9:0]] <= RegVal;
  end
  assign Data_out = (Rm && address <= 16'd512) ? mem[address[9:0]] : 16'hDEAD;

  typedef struct {
    logic r0; logic w0; logic [15:0] a0; logic [15:0] d0;
    logic r1; logic w1; logic [15:0] a1; logic [15:0] d1;
    logic port; logic rm; logic wm; logic err;
    logic [15:0] addr; logic [15:0] rd0; logic [15:0] rd1;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction from an IDLE cycle; caller is at posedge+1 in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    tick();
    chk({tag, ".acc_busy"}, busy, 1'b1);
    chk({tag, ".acc_rm"},   Rm, v.rm);
    chk({tag, ".acc_wm"},   Wm, v.wm);
    chk({tag, ".acc_addr"}, address, v.addr);
    chk({tag, ".acc_ack"},  {ack0, ack1}, 2'b00);
    if (v.port) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk({tag, ".resp_ack"},  {ack0, ack1}, {!v.port, v.port});
    chk({tag, ".resp_err"},  {err0, err1}, {!v.port && v.err, v.port && v.err});
    chk({tag, ".resp_strb"}, {Rm, Wm}, 2'b00);
    chk({tag, ".rdata0"},    rdata0, v.rd0);
    chk({tag, ".rdata1"},    rdata1, v.rd1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".idle_ack"},  {ack0, ack1, Wm, Rm}, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wm, n_rm;
    for (int i = 0; i <= 512; i++) mem[i] = 16'h0000;

    vecs[0]  = '{1,1,16'h0005,16'h1234, 0,0,16'h0000,16'h0000, 0,0,1,0, 16'h0005,16'h0000,16'h0000};
    vecs[1]  = '{1,0,16'h0005,16'h0000, 0,0,16'h0000,16'h0000, 0,1,0,0, 16'h0005,16'h1234,16'h0000};
    vecs[2]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'hBEEF, 1,0,1,0, 16'h0200,16'h1234,16'h0000};
    vecs[3]  = '{0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 1,1,0,0, 16'h0200,16'h1234,16'hBEEF};
    vecs[4]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0201,16'h1111, 1,0,0,1, 16'h0201,16'h1234,16'hBEEF};
    vecs[5]  = '{0,0,16'h0000,16'h0000, 1,0,16'hFFFF,16'h0000, 1,0,0,1, 16'hFFFF,16'h1234,16'h0000};
    vecs[6]  = '{0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 1,1,0,0, 16'h0200,16'h1234,16'hBEEF};
    vecs[7]  = '{1,0,16'h0200,16'h0000, 1,0,16'h0005,16'h0000, 0,1,0,0, 16'h0200,16'hBEEF,16'hBEEF};
    vecs[8]  = '{1,1,16'h0006,16'h7777, 1,1,16'h0007,16'h2222, 1,0,1,0, 16'h0007,16'hBEEF,16'hBEEF};
    vecs[9]  = '{1,0,16'h0007,16'h0000, 0,0,16'h0000,16'h0000, 0,1,0,0, 16'h0007,16'h2222,16'hBEEF};
    vecs[10] = '{1,0,16'h0006,16'h0000, 0,0,16'h0000,16'h0000, 0,1,0,0, 16'h0006,16'h0000,16'hBEEF};
    vecs[11] = '{0,0,16'h0000,16'h0000, 1,0,16'h0005,16'h0000, 1,1,0,0, 16'h0005,16'h0000,16'h1234};
    vecs[12] = '{0,0,16'h0000,16'h0000, 1,1,16'h0010,16'h00C3, 1,0,1,0, 16'h0010,16'h0000,16'h1234};

    // Reset held two cycles with both requests high.
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004; wdata1 = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst.ctl",   {busy, Rm, Wm, ack0, ack1, err0, err1}, 7'b0);
      chk("rst.rdata", {rdata0, rdata1}, 32'h0);
      chk("rst.bus",   {address, RegVal}, 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("rst.first_grant_addr", address, 16'h0003);
    chk("rst.first_grant_rm",   Rm, 1'b1);
    req1 = 1'b0;
    tick();
    chk("rst.first_ack", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("rst.idle", busy, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i <= 12; i++) run_vec(vecs[i], i);
    chk("mem512", mem[512], 16'hBEEF);

    // Both ports held continuously: alternating grants, 3 cycles apart.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0011; wdata1 = 16'h00AA;
    n_wm = 0; n_rm = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (Wm) n_wm++;
      if (Rm) n_rm++;
      chk($sformatf("cont.ack_k%0d", k), {ack0, ack1}, {(k == 2 || k == 8), (k == 5 || k == 11)});
      if (k == 2 || k == 8)  chk($sformatf("cont.rdata0_k%0d", k), rdata0, 16'h00C3);
      if (k == 5 || k == 11) chk($sformatf("cont.rdata1_k%0d", k), rdata1, 16'h1234);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("cont.idle", busy, 1'b0);
    chk("cont.wm_cycles", n_wm, 2);
    chk("cont.rm_cycles", n_rm, 2);
    chk("cont.mem11", mem[16'h0011], 16'h00AA);

    // Reset sampled in ACCESS of a write: write already committed, no ack.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h5555;
    tick();
    chk("rstacc.wm", Wm, 1'b1);
    reset = 1'b1;
    tick();
    chk("rstacc.after", {busy, Wm, ack0, ack1}, 4'b0000);
    reset = 1'b0; req0 = 1'b0;
    tick();
    chk("rstacc.noack1", {busy, ack0, ack1}, 3'b000);
    tick();
    chk("rstacc.noack2", {busy, ack0, ack1}, 3'b000);
    run_vec('{1,0,16'h0020,16'h0000, 0,0,16'h0000,16'h0000, 0,1,0,0, 16'h0020,16'h5555,16'h0000}, 13);

    // Port 1 request pulsed only during port 0's ACCESS is never served.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
    tick();
    req1 = 1'b0;
    chk("drop.ack",    {ack0, ack1}, 2'b10);
    chk("drop.rdata0", rdata0, 16'h1234);
    req0 = 1'b0;
    tick();
    chk("drop.idle", busy, 1'b0);
    tick();
    chk("drop.noack1", {busy, ack1, ack0}, 3'b000);
    chk("drop.rdata1", rdata1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
